// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the N-bit counter datapath (start/pause/terminal/stop).
// Define COUNTER_SEQ_CTRL_OVF_COUNT_EN to add the saturating reload_cnt output.
module counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int OVF_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode_reload,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o
`ifdef COUNTER_SEQ_CTRL_OVF_COUNT_EN
    ,
    output logic [OVF_W-1:0] reload_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             wrap;
    logic             ev_clr;
    logic             at_term;

    assign at_term = (count_q == term_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = term_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        wrap    = 1'b0;
        ev_clr  = stop;
        unique case (state_q)
            IDLE: begin
                if (start && stop) begin
                    count_d = '0;
                end else if (start) begin
                    term_d  = term_val;
                    mode_d  = mode_reload;
                    count_d = '0;
                    ev_clr  = 1'b1;
                    if (term_val == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (at_term && !mode_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (at_term) begin
                    // auto-reload: wrap and pulse, stay running
                    count_d = '0;
                    done_d  = 1'b1;
                    wrap    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (stop) begin
                    count_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            term_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign state_o = state_q;
    assign busy    = (state_q != IDLE);

`ifdef COUNTER_SEQ_CTRL_OVF_COUNT_EN
    logic [OVF_W-1:0] rl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rl_q <= '0;
        end else if (ev_clr) begin
            rl_q <= '0;
        end else if (wrap && (rl_q != {OVF_W{1'b1}})) begin
            rl_q <= rl_q + 1'b1;
        end
    end

    assign reload_cnt = rl_q;
`else
    logic unused_ev;
    assign unused_ev = wrap ^ ev_clr;
`endif

endmodule
